// File: rtl/mem_shadow_pkg.sv
// mem_shadow_pkg: shared types for the shadow transfer engine.
// Command opcodes and the transfer FSM state encoding.
package mem_shadow_pkg;

    typedef enum logic {
        XferPreload = 1'b0,
        XferDump    = 1'b1
    } xfer_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StPreload,
        StDump,
        StDone
    } xfer_state_e;

endpackage

// File: rtl/mem_shadow_xfer_fifo.sv
// mem_shadow_xfer_fifo: 2-entry valid/ready FIFO for dump read data.
// Push and pop may coincide; the occupancy is then unchanged.
module mem_shadow_xfer_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              push;
    logic              pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = cnt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/mem_shadow_xfer.sv
// mem_shadow_xfer: host preload/dump engine for the memory-shadow port.
// Optional running checksum output under MEM_SHADOW_XFER_CSUM_EN.
module mem_shadow_xfer
    import mem_shadow_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 17
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] shd_addr_o,
    output logic [DATA_W-1:0] shd_wdata_o,
    output logic              shd_we_o,
    output logic              shd_re_o,
    input  logic [DATA_W-1:0] shd_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
`ifdef MEM_SHADOW_XFER_CSUM_EN
    ,
    output logic [31:0]       csum_o
`endif
);

    // One past the last legal word address, in LEN_W+1 bits.
    localparam logic [LEN_W:0] Space =
        {{(LEN_W-ADDR_W){1'b0}}, 1'b1, {ADDR_W{1'b0}}};

    xfer_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  pop_rem_q;
    logic              inflight_q;
    logic              err_q;
    logic [LEN_W:0]    span;
    logic              accept, range_err, len_zero, go;
    logic              cmd_dump, go_dump;
    logic              beat, issue, pop, credit_ok;
    logic              fifo_in_ready;
    logic [1:0]        fifo_cnt;

    assign span      = (LEN_W+1)'(cmd_addr_i) + (LEN_W+1)'(cmd_len_i);
    assign range_err = (span > Space);
    assign len_zero  = (cmd_len_i == '0);
    assign cmd_dump  = (xfer_op_e'(cmd_op_i) == XferDump);
    assign accept    = cmd_valid_i & (state_q == StIdle);
    assign go        = accept & ~range_err & ~len_zero;
    // First dump read leaves in the acceptance cycle.
    assign go_dump   = go & cmd_dump;

    assign beat      = (state_q == StPreload) & wr_valid_i;
    assign pop       = rd_valid_o & rd_ready_i;
    // A pop this cycle frees a slot for a read issued this cycle.
    assign credit_ok = (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < 3'd2)
                     | pop;
    assign issue     = go_dump
                     | ((state_q == StDump) & (rem_q != '0) & credit_ok);

    assign shd_we_o    = beat;
    assign shd_re_o    = issue;
    assign shd_wdata_o = beat ? wr_data_i : '0;
    assign shd_addr_o  = go_dump          ? cmd_addr_i :
                         (beat | issue)   ? addr_q     : '0;
    assign err_o       = err_q;

    // Transfer FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        wr_ready_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                if (accept) begin
                    if (!go) begin
                        state_d = StDone;
                    end else if (cmd_dump) begin
                        state_d = StDump;
                    end else begin
                        state_d = StPreload;
                    end
                end
            end
            StPreload: begin
                busy_o     = 1'b1;
                wr_ready_o = 1'b1;
                if (beat && rem_q == LEN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDump: begin
                busy_o = 1'b1;
                if (pop && pop_rem_q == LEN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address, word counters, read-in-flight flag and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            rem_q      <= '0;
            pop_rem_q  <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                err_q     <= range_err;
                addr_q    <= cmd_addr_i + ADDR_W'(go_dump);
                rem_q     <= cmd_len_i - LEN_W'(go_dump);
                pop_rem_q <= cmd_len_i;
            end else begin
                if (beat || issue) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    rem_q  <= rem_q - LEN_W'(1);
                end
                if (pop) begin
                    pop_rem_q <= pop_rem_q - LEN_W'(1);
                end
            end
        end
    end

    mem_shadow_xfer_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (inflight_q & fifo_in_ready),
        .in_ready  (fifo_in_ready),
        .in_data   (shd_rdata_i),
        .out_valid (rd_valid_o),
        .out_ready (rd_ready_i),
        .out_data  (rd_data_o),
        .count     (fifo_cnt)
    );

`ifdef MEM_SHADOW_XFER_CSUM_EN
    logic [31:0] csum_q;

    // Running checksum of preload beats and dump pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (beat) begin
            csum_q <= csum_q + 32'(wr_data_i);
        end else if (pop) begin
            csum_q <= csum_q + 32'(rd_data_o);
        end
    end

    assign csum_o = csum_q;
`endif

endmodule

// File: tb/tb_mem_shadow_xfer.sv
// tb_mem_shadow_xfer: command table plus scoreboard for mem_shadow_xfer.
// Shadow memory is modelled here with a 1-cycle read latency.
module tb_mem_shadow_xfer;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready_o, cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready_o;
    logic [DW-1:0] wr_data;
    logic          rd_valid_o, rd_ready;
    logic [DW-1:0] rd_data_o;
    logic [AW-1:0] shd_addr_o;
    logic [DW-1:0] shd_wdata_o;
    logic          shd_we_o, shd_re_o;
    logic [DW-1:0] shd_rdata;
    logic          busy_o, done_o, err_o;
`ifdef MEM_SHADOW_XFER_CSUM_EN
    logic [31:0]   csum;
`endif

    always #5 clk = ~clk;

    mem_shadow_xfer #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready_o),
        .wr_data_i   (wr_data),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready),
        .rd_data_o   (rd_data_o),
        .shd_addr_o  (shd_addr_o),
        .shd_wdata_o (shd_wdata_o),
        .shd_we_o    (shd_we_o),
        .shd_re_o    (shd_re_o),
        .shd_rdata_i (shd_rdata),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
`ifdef MEM_SHADOW_XFER_CSUM_EN
        ,
        .csum_o      (csum)
`endif
    );

    // Shadow memory seen by the DUT.
    logic [31:0] shd_mem [256];
    logic        load_mem;
    logic [31:0] ref_mem [256];
    int          re_total, we_total, pop_total;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int k = 0; k < 256; k++) shd_mem[k] <= 32'(k * 16);
        end else begin
            if (shd_we_o) shd_mem[shd_addr_o] <= shd_wdata_o;
            if (shd_re_o) shd_rdata <= shd_mem[shd_addr_o];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_total  <= 0;
            we_total  <= 0;
            pop_total <= 0;
        end else begin
            re_total  <= re_total + int'(shd_re_o);
            we_total  <= we_total + int'(shd_we_o);
            pop_total <= pop_total + int'(rd_valid_o && rd_ready);
        end
    end

    typedef struct {
        logic op;
        int   addr;
        int   len;
        int   rmode;
        bit   gaps;
        logic exp_err;
        int   exp_lat;
    } vec_t;

    vec_t        vecs [10];
    logic [39:0] wq [$];
    logic [31:0] rq [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          pops = 0;
    logic        acc_seen, last_beat;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic [39:0] ew;
        logic [31:0] er;
        acc_seen  = cmd_valid && cmd_ready_o;
        last_beat = wr_valid && wr_ready_o;
        chk("we_re_excl", {shd_we_o, shd_re_o} == 2'b11, 0);
        if (shd_we_o) begin
            if (wq.size() != 0) ew = wq.pop_front();
            else ew = 'x;
            chk("wr_beat", {shd_addr_o, shd_wdata_o}, ew);
        end
        if (rd_valid_o && rd_ready) begin
            pops++;
            if (rq.size() != 0) er = rq.pop_front();
            else er = 'x;
            chk("rd_word", rd_data_o, er);
        end
        if (busy_o) chk("outstanding", (re_total - pop_total) <= 2, 1);
        if (done_o) done_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_wr_ready", wr_ready_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_shd_addr", shd_addr_o, 0);
        chk("rst_shd_wdata", shd_wdata_o, 0);
        chk("rst_shd_we", shd_we_o, 0);
        chk("rst_shd_re", shd_re_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
    endtask

    task automatic run_cmd(input vec_t v);
        int we0, re0, dn0, guard, i;
        we0 = we_total;
        re0 = re_total;
        dn0 = done_cnt;
        if (v.op && !v.exp_err)
            for (int k = 0; k < v.len; k++)
                rq.push_back(ref_mem[(v.addr + k) % 256]);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = AW'(v.addr);
        cmd_len   = LW'(v.len);
        rd_ready  = (v.rmode == 1);
        tick();
        chk("cmd_accept", acc_seen, 1);
        cmd_valid = 1'b0;
        if (!v.op && !v.exp_err) begin
            i = 0;
            guard = 0;
            while (i < v.len && guard < 4000) begin
                if (!wr_valid && (!v.gaps || $urandom_range(3) != 0)) begin
                    wr_valid = 1'b1;
                    wr_data  = $urandom;
                    wq.push_back({AW'(v.addr + i), wr_data});
                    ref_mem[(v.addr + i) % 256] = wr_data;
                end
                tick();
                if (last_beat) begin
                    i++;
                    wr_valid = 1'b0;
                end
                guard++;
            end
            wr_valid = 1'b0;
            chk("beats_done", i, v.len);
        end
        guard = 0;
        while (done_cnt == dn0 && guard < 3000) begin
            rd_ready = (v.rmode == 2) ? 1'($urandom_range(1)) : 1'b1;
            tick();
            guard++;
        end
        rd_ready = 1'b0;
        chk("done_pulse", done_cnt - dn0, 1);
        if (v.exp_lat != 0) chk("done_latency", guard, v.exp_lat);
        chk("err_o", err_o, v.exp_err);
        chk("done_1cyc", done_o, 0);
        chk("cmd_ready_back", cmd_ready_o, 1);
        chk("we_strobes", we_total - we0,
            (!v.op && !v.exp_err) ? v.len : 0);
        chk("re_strobes", re_total - re0,
            (v.op && !v.exp_err) ? v.len : 0);
        chk("sb_empty", wq.size() + rq.size(), 0);
        wq.delete();
        rq.delete();
    endtask

    initial begin
        vec_t v;
        int   guard, p0;
        vecs[0] = '{1'b1, 0,   16,  1, 1'b0, 1'b0, 18};
        vecs[1] = '{1'b0, 4,   3,   0, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b1, 0,   64,  2, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b0, 0,   256, 0, 1'b1, 1'b0, 1};
        vecs[4] = '{1'b0, 1,   256, 0, 1'b0, 1'b1, 1};
        vecs[5] = '{1'b1, 1,   256, 1, 1'b0, 1'b1, 1};
        vecs[6] = '{1'b1, 9,   0,   1, 1'b0, 1'b0, 1};
        vecs[7] = '{1'b1, 250, 6,   1, 1'b0, 1'b0, 8};
        vecs[8] = '{1'b0, 255, 1,   0, 1'b0, 1'b0, 1};
        vecs[9] = '{1'b1, 0,   256, 2, 1'b0, 1'b0, 0};
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'(k * 16);

        rst_n     = 1'b0;
        load_mem  = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 10; n++) run_cmd(vecs[n]);

        // Reset in the middle of a dump, then dump again.
        for (int k = 0; k < 32; k++) rq.push_back(ref_mem[k]);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_addr  = '0;
        cmd_len   = LW'(32);
        rd_ready  = 1'b1;
        tick();
        chk("mid_accept", acc_seen, 1);
        cmd_valid = 1'b0;
        p0 = pops;
        guard = 0;
        while (pops - p0 < 5 && guard < 100) begin
            tick();
            guard++;
        end
        chk("pops_before_reset", pops - p0, 5);
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        rq.delete();
        rd_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        v = '{1'b1, 0, 8, 2, 1'b0, 1'b0, 0};
        run_cmd(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
